// File: rtl/raster_pkg.sv
// Shared types and sizing helpers for the bounding-box raster scanner.
package raster_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int RASTER_CW_DEFAULT = 8;

    // A full (2^cw)^2 box needs 2*cw bits plus one to hold the final count.
    function automatic int raster_count_width(input int cw);
        return 2 * cw + 1;
    endfunction

endpackage

// File: rtl/raster_scanner_if.sv
// Pixel stream from the raster scanner to the downstream edge-test stage.
interface raster_scanner_if
    import raster_pkg::*;
#(
    parameter int CW = RASTER_CW_DEFAULT
);
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_last;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;

    modport master (output pix_valid, pix_x, pix_y, pix_last, input pix_ready);
    modport slave  (input pix_valid, pix_x, pix_y, pix_last, output pix_ready);
endinterface

// File: rtl/raster_axis_step.sv
// One-axis stepper: advances x toward the row end, or reloads the next row start when the end is reached.
module raster_axis_step #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] row_start,
    input  logic [CW-1:0] row_end,
    input  logic          dir_up,
    output logic [CW-1:0] x_next,
    output logic          row_done
);

    assign row_done = (x == row_end);

    // The step past the row end is never selected, so x never wraps.
    always_comb begin
        x_next = x;
        if (row_done) begin
            x_next = row_start;
        end else if (dir_up) begin
            x_next = x + 1'b1;
        end else begin
            x_next = x - 1'b1;
        end
    end

endmodule

// File: rtl/raster_scanner.sv
// Bounding-box raster scanner: sorts two corners and streams every pixel row by row.
// Define RASTER_SERPENTINE_EN for boustrophedon order (odd rows run x_hi down to x_lo).
module raster_scanner
    import raster_pkg::*;
#(
    parameter int CW = RASTER_CW_DEFAULT,
    parameter int NW = raster_count_width(CW)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CW-1:0]           xa,
    input  logic [CW-1:0]           xb,
    input  logic [CW-1:0]           ya,
    input  logic [CW-1:0]           yb,
    raster_scanner_if.master        pix,
    output logic                    busy,
    output logic                    done,
    output logic [NW-1:0]           pix_cnt
);

    state_t        state, state_nxt;
    logic [CW-1:0] x_lo, x_hi, y_lo, y_hi;
    logic [CW-1:0] x_cur, y_cur;
    logic [CW-1:0] x_next, row_end, row_start_nxt;
    logic          dir_up, row_done, xfer, last;

`ifdef RASTER_SERPENTINE_EN
    logic row_odd;

    assign dir_up        = ~row_odd;
    assign row_end       = row_odd ? x_lo : x_hi;
    // The next row begins at the column where this one finished.
    assign row_start_nxt = row_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_odd <= 1'b0;
        end else if (state == IDLE && start) begin
            row_odd <= 1'b0;
        end else if (xfer && row_done && !last) begin
            row_odd <= ~row_odd;
        end
    end
`else
    assign dir_up        = 1'b1;
    assign row_end       = x_hi;
    assign row_start_nxt = x_lo;
`endif

    raster_axis_step #(.CW(CW)) u_step (
        .x         (x_cur),
        .row_start (row_start_nxt),
        .row_end   (row_end),
        .dir_up    (dir_up),
        .x_next    (x_next),
        .row_done  (row_done)
    );

    assign xfer = (state == SCAN) && pix.pix_ready;
    assign last = (state == SCAN) && (y_cur == y_hi) && row_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort wins over the final transfer's move to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (xfer && last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_lo    <= '0;
            x_hi    <= '0;
            y_lo    <= '0;
            y_hi    <= '0;
            x_cur   <= '0;
            y_cur   <= '0;
            pix_cnt <= '0;
        end else if (state == IDLE && start) begin
            x_lo    <= (xa < xb) ? xa : xb;
            x_hi    <= (xa < xb) ? xb : xa;
            y_lo    <= (ya < yb) ? ya : yb;
            y_hi    <= (ya < yb) ? yb : ya;
            x_cur   <= (xa < xb) ? xa : xb;
            y_cur   <= (ya < yb) ? ya : yb;
            pix_cnt <= '0;
        end else if (xfer) begin
            pix_cnt <= pix_cnt + 1'b1;
            // Coordinates freeze on the final pixel so y never steps past y_hi.
            if (!last) begin
                x_cur <= x_next;
                if (row_done) begin
                    y_cur <= y_cur + 1'b1;
                end
            end
        end
    end

    assign pix.pix_valid = (state == SCAN);
    assign pix.pix_x     = x_cur;
    assign pix.pix_y     = y_cur;
    assign pix.pix_last  = last;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

endmodule

// File: tb/tb_raster_scanner.sv
// Scoreboard bench for raster_scanner: a CW=8 instance for directed boxes and a CW=3 instance for the full-range box.
`timescale 1ns/1ps
module tb_raster_scanner;
    import raster_pkg::*;

`ifdef RASTER_SERPENTINE_EN
    localparam bit SERP = 1'b1;
`else
    localparam bit SERP = 1'b0;
`endif

    typedef struct {
        int x;
        int y;
        bit last;
    } pix_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, abort;
    logic [7:0]  xa, xb, ya, yb;
    logic        busy, done;
    logic [16:0] pix_cnt;

    logic        start3, abort3;
    logic [2:0]  xa3, xb3, ya3, yb3;
    logic        busy3, done3;
    logic [6:0]  pix_cnt3;

    raster_scanner_if #(.CW(8)) pif ();
    raster_scanner_if #(.CW(3)) pif3 ();

    raster_scanner #(.CW(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .xa(xa), .xb(xb), .ya(ya), .yb(yb),
        .pix(pif), .busy(busy), .done(done), .pix_cnt(pix_cnt)
    );

    raster_scanner #(.CW(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .xa(xa3), .xb(xb3), .ya(ya3), .yb(yb3),
        .pix(pif3), .busy(busy3), .done(done3), .pix_cnt(pix_cnt3)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    pix_t q8[$];
    pix_t q3[$];
    pix_t e8, e3;
    logic       stall_v;
    logic [7:0] stall_x, stall_y;
    logic       stall_l;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor for the CW=8 instance: pops one expectation per accepted pixel.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v && pif.pix_valid) begin
                check("stall_x", pif.pix_x, stall_x);
                check("stall_y", pif.pix_y, stall_y);
                check("stall_last", pif.pix_last, stall_l);
            end
            if (pif.pix_valid && pif.pix_ready) begin
                if (q8.size() == 0) begin
                    check("unexpected_pixel", 1, 0);
                end else begin
                    e8 = q8.pop_front();
                    check("pix_x", pif.pix_x, e8.x);
                    check("pix_y", pif.pix_y, e8.y);
                    check("pix_last", pif.pix_last, e8.last);
                end
            end
            stall_v = pif.pix_valid && !pif.pix_ready;
            stall_x = pif.pix_x;
            stall_y = pif.pix_y;
            stall_l = pif.pix_last;
        end
    end

    always @(negedge clk) begin
        if (rst_n && pif3.pix_valid && pif3.pix_ready) begin
            if (q3.size() == 0) begin
                check("unexpected_pixel3", 1, 0);
            end else begin
                e3 = q3.pop_front();
                check("pix_x3", pif3.pix_x, e3.x);
                check("pix_y3", pif3.pix_y, e3.y);
                check("pix_last3", pif3.pix_last, e3.last);
            end
        end
    end

    task automatic push_box(input int xl, input int xh, input int yl, input int yh, input int limit);
        pix_t p;
        int   n;
        int   w;
        n = 0;
        w = xh - xl + 1;
        for (int r = 0; r <= yh - yl; r++) begin
            for (int i = 0; i < w; i++) begin
                p.y    = yl + r;
                p.x    = (SERP && (r % 2 == 1)) ? xh - i : xl + i;
                p.last = (r == yh - yl) && (i == w - 1);
                if (n < limit) q8.push_back(p);
                n++;
            end
        end
    endtask

    // mode 0: ready tied high; mode 1: ready toggles 1/0. abort_at>0 aborts on that transfer.
    task automatic do_job(input int a, input int b, input int c, input int d,
                          input int mode, input int abort_at, input string tag);
        int xl, xh, yl, yh, area, exp_n, nx, cyc;
        bit fin, was_abort;
        xl = (a < b) ? a : b;  xh = (a < b) ? b : a;
        yl = (c < d) ? c : d;  yh = (c < d) ? d : c;
        area  = (xh - xl + 1) * (yh - yl + 1);
        exp_n = (abort_at > 0) ? abort_at : area;
        nx = 0; cyc = 0; fin = 1'b0; was_abort = 1'b0;
        push_box(xl, xh, yl, yh, exp_n);
        xa = 8'(a); xb = 8'(b); ya = 8'(c); yb = 8'(d);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_first_valid"}, pif.pix_valid, 1);
        check({tag, "_first_busy"}, busy, 1);
        check({tag, "_first_cnt"}, pix_cnt, 0);
        check({tag, "_first_last"}, pif.pix_last, (area == 1) ? 1 : 0);
        while (!fin && cyc < 5000) begin
            pif.pix_ready = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
            abort = (abort_at > 0) && pif.pix_valid && pif.pix_ready && (nx + 1 == abort_at);
            if (pif.pix_valid && pif.pix_ready) nx++;
            was_abort = abort;
            @(posedge clk); #1;
            abort = 1'b0;
            cyc++;
            if (was_abort || done) fin = 1'b1;
        end
        pif.pix_ready = 1'b1;
        if (!fin) check({tag, "_timeout"}, 0, 1);
        check({tag, "_accepted"}, nx, exp_n);
        check({tag, "_queue_empty"}, q8.size(), 0);
        if (abort_at > 0) begin
            check({tag, "_abort_valid"}, pif.pix_valid, 0);
            check({tag, "_abort_busy"}, busy, 0);
            check({tag, "_abort_done"}, done, 0);
            check({tag, "_abort_cnt"}, pix_cnt, exp_n);
            @(posedge clk); #1;
            check({tag, "_abort_no_done"}, done, 0);
        end else begin
            check({tag, "_done"}, done, 1);
            check({tag, "_done_busy"}, busy, 1);
            check({tag, "_done_valid"}, pif.pix_valid, 0);
            check({tag, "_cnt"}, pix_cnt, exp_n);
            if (mode == 0) check({tag, "_cycles"}, cyc, area);
            @(posedge clk); #1;
            check({tag, "_done_pulse"}, done, 0);
            check({tag, "_idle_busy"}, busy, 0);
            check({tag, "_cnt_hold"}, pix_cnt, exp_n);
        end
        q8.delete();
    endtask

    initial begin
        int cyc;
        pix_t p;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        xa = '0; xb = '0; ya = '0; yb = '0;
        start3 = 1'b0; abort3 = 1'b0;
        xa3 = '0; xb3 = '0; ya3 = '0; yb3 = '0;
        pif.pix_ready = 1'b1;
        pif3.pix_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", pif.pix_valid, 0);
        check("rst_last", pif.pix_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_x", pif.pix_x, 0);
        check("rst_y", pif.pix_y, 0);
        check("rst_cnt", pix_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_job(5, 2, 7, 6, 0, 0, "box4x2");
        do_job(5, 2, 7, 6, 1, 0, "box4x2_stall");
        do_job(3, 3, 3, 3, 0, 0, "single");
        do_job(4, 4, 3, 1, 1, 0, "column");
        do_job(9, 6, 2, 2, 0, 0, "row");
        do_job(0, 3, 0, 3, 0, 3, "abort3");
        do_job(2, 0, 1, 0, 0, 0, "box3x2");
        do_job(255, 252, 255, 253, 0, 0, "edge_max");

        // Reset in the middle of a job clears everything immediately.
        push_box(10, 19, 10, 19, 4);
        xa = 8'd10; xb = 8'd19; ya = 8'd10; yb = 8'd19;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", pif.pix_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_x", pif.pix_x, 0);
        check("midrst_cnt", pix_cnt, 0);
        q8.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-range box on the CW=3 instance.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) begin
                p.y    = r;
                p.x    = (SERP && (r % 2 == 1)) ? 7 - i : i;
                p.last = (r == 7) && (i == 7);
                q3.push_back(p);
            end
        end
        xa3 = 3'd7; xb3 = 3'd0; ya3 = 3'd0; yb3 = 3'd7;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        cyc = 0;
        while (!done3 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("full_done", done3, 1);
        check("full_cycles", cyc, 64);
        check("full_cnt", pix_cnt3, 64);
        check("full_queue_empty", q3.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/raster_scanner.md
# raster_scanner

Parametrised bounding-box raster scanner for the triangle rendering engine. On `start` it latches two corner coordinates, sorts them into an inclusive box, and walks every pixel row by row. Each pixel is presented to the downstream edge-test stage over a valid/ready handshake. It is the generalised successor of the fixed 3-bit scan counter: configurable coordinate width, backpressure, abort, pixel count, and an optional serpentine order.

## Interface
- `CW`, 8: coordinate width in bits, 2..12.
- `NW`, 2*CW+1: pixel-count width; holds (2^CW)^2 exactly.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a job; sampled only in IDLE.
- `abort` in 1: cancel the current job; effective in SCAN only.
- `xa`, `xb` in CW: x corners, any order; sampled with `start`.
- `ya`, `yb` in CW: y corners, any order; sampled with `start`.
- `pix_valid` out 1: `pix_x`/`pix_y` hold a pixel.
- `pix_ready` in 1: downstream accepts the pixel.
- `pix_x`, `pix_y` out CW: current pixel coordinate.
- `pix_last` out 1: the current pixel is the final one of the box.
- `busy` out 1: high in SCAN and DONE.
- `done` out 1: one-cycle pulse after the last pixel is accepted.
- `pix_cnt` out NW: pixels accepted in the current or most recent job.

## Operation
- States: IDLE, SCAN, DONE. Encoding is defined in the package.
- IDLE with `start`=1:
  - latch `x_lo=min(xa,xb)`, `x_hi=max(xa,xb)`, `y_lo=min(ya,yb)`, `y_hi=max(ya,yb)`;
  - load `pix_x`=row start, `pix_y=y_lo`, clear `pix_cnt`;
  - go to SCAN.
- SCAN:
  - `pix_valid`=1 throughout.
  - A transfer occurs when `pix_valid && pix_ready`; each transfer increments `pix_cnt`.
  - Non-end transfer: x steps toward the row end.
  - Transfer at the row end: x reloads the next row start and y increments.
  - While `pix_ready`=0, `pix_x`, `pix_y` and `pix_last` hold stable.
- `pix_last` = (y == `y_hi`) && (x == row end); purely combinational from state.
- Transfer with `pix_last`=1 → DONE. DONE lasts exactly one cycle with `done`=1, then returns to IDLE.
- `abort`=1 in SCAN → IDLE next cycle, no `done`.
  - A handshake in the same cycle still counts in `pix_cnt`.
  - Abort has priority over advancing to DONE.
- `start` is ignored outside IDLE. `abort` is ignored outside SCAN.
- Degenerate boxes:
  - `xa==xb`: one-column box.
  - `ya==yb`: one-row box.
  - Both equal: a single pixel, with `pix_last`=1 on the first cycle of SCAN.
- Full-range box (0..2^CW−1): no wrap-around. Stepping stops at `x_hi`/`y_hi` and never overflows CW. All coordinate arithmetic is unsigned CW-bit.
- `pix_cnt` holds its value after DONE/IDLE until the next `start`.

## Timing
- Reset values:
  - state IDLE;
  - `pix_valid`, `pix_last`, `busy`, `done` = 0;
  - `pix_x`, `pix_y`, `pix_cnt` = 0.
- `start` at edge N → first pixel valid in cycle N+1.
- Throughput: one pixel per cycle while `pix_ready`=1.
- Last transfer at edge M → `done`=1 in cycle M+1 → IDLE in M+2. `start` is accepted from M+2.
- Job with `pix_ready` tied high: W·H pixel cycles + 1 DONE cycle.
- Reset mid-job: immediate return to IDLE; all outputs take their reset values asynchronously.

## Configuration
- `RASTER_SERPENTINE_EN` defined:
  - rows at an even offset from `y_lo` run `x_lo`→`x_hi`; odd-offset rows run `x_hi`→`x_lo`;
  - row start/end swap per row, and `pix_last` uses the final row's end.
- Not defined: every row runs `x_lo`→`x_hi`; the row-parity register is not built.

## Structure
- Package `raster_pkg`:
  - state enum (IDLE/SCAN/DONE);
  - default `CW`;
  - function for count width `NW`.
- Sub-module `raster_axis_step`: given the current x, row start, row end and direction, produces the next x and an end-of-row flag. Instantiated once.

## Test plan
- CW=8, `xa`=5, `xb`=2, `ya`=7, `yb`=6, `pix_ready`=1 → pixels (2,6)…(5,6),(2,7)…(5,7); `pix_last` only on (5,7); `pix_cnt`=8; `done` pulses one cycle after.
- Same box, `pix_ready` toggling 1/0 → identical sequence; coordinates stable during stalls.
- Single pixel: `xa`=`xb`=3, `ya`=`yb`=3 → one transfer of (3,3) with `pix_last`=1; `pix_cnt`=1.
- Full range, CW=3: box 0..7 × 0..7 → 64 pixels with no wrap; last pixel is (7,7).
- `abort` asserted on the 3rd transfer of a 4×4 box → IDLE next cycle; no `done`; `pix_cnt`=3.
- `RASTER_SERPENTINE_EN`, box x 0..2, y 0..1 → (0,0),(1,0),(2,0),(2,1),(1,1),(0,1); `pix_last` on (0,1).
